// File: rtl/reg_file_2r1w_if.sv
// Register-file access bus: one write port with commit acknowledge and
// two combinational read ports. The datapath side is the master.
interface reg_file_2r1w_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [ADDR_WIDTH-1:0] rd_addr_a;
  logic [ADDR_WIDTH-1:0] rd_addr_b;
  logic [DATA_WIDTH-1:0] rd_data_a;
  logic [DATA_WIDTH-1:0] rd_data_b;
  logic                  wr_ack;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b, wr_ack
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b, wr_ack
  );
endinterface

// File: rtl/reg_file_2r1w.sv
// MIPS general-purpose register file: 32 entries, two combinational read
// ports with same-cycle write-through bypass, one synchronous write port.
// Register $zero is hardwired to zero.
module reg_file_2r1w #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  reg_file_2r1w_if.slave   bus
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]   wr_sel;
  logic                  wr_ack_q;
  logic [DATA_WIDTH-1:0] rd_a;
  logic [DATA_WIDTH-1:0] rd_b;

  // Decode the destination index into one-hot write enables; $zero masked.
  // Indexing only under wr_en keeps an unknown wr_addr from touching wr_sel.
  always_comb begin
    wr_sel = '0;
    if (bus.wr_en) begin
      wr_sel[bus.wr_addr] = 1'b1;
    end
    wr_sel[0] = 1'b0;
  end

  // Register array: async clear, per-entry write on the decoded enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
        if (wr_sel[i]) begin
          regs[i] <= bus.wr_data;
        end
      end
    end
  end

  // One-cycle acknowledge for every write that actually commits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ack_q <= 1'b0;
    end else begin
      wr_ack_q <= |wr_sel;
    end
  end

  // Read port A: zero, then bypass, then array. Reset also suppresses the
  // bypass so both ports read 0 while rst_n is low.
  always_comb begin
    rd_a = '0;
    if (rst_n && (bus.rd_addr_a != '0)) begin
      if (bus.wr_en && (bus.wr_addr == bus.rd_addr_a)) begin
        rd_a = bus.wr_data;
      end else begin
        rd_a = regs[bus.rd_addr_a];
      end
    end
  end

  // Read port B: same priority as port A, evaluated independently.
  always_comb begin
    rd_b = '0;
    if (rst_n && (bus.rd_addr_b != '0)) begin
      if (bus.wr_en && (bus.wr_addr == bus.rd_addr_b)) begin
        rd_b = bus.wr_data;
      end else begin
        rd_b = regs[bus.rd_addr_b];
      end
    end
  end

  assign bus.rd_data_a = rd_a;
  assign bus.rd_data_b = rd_b;
  assign bus.wr_ack    = wr_ack_q;

endmodule

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
- 32-entry MIPS general-purpose register file with two asynchronous read ports and one synchronous write port.
- Sits at the far end of the destination-register path. The 5-bit write address chosen upstream (rt or rd) is decoded here into one-hot write enables, which is the demultiplex direction of that selection.
- Supplies rs/rt operands to the ALU stage.
- Register $zero (index 0) is hardwired to zero.

Parameters:
- DATA_WIDTH, 32, width of each register and data port.
- ADDR_WIDTH, 5, width of register address ports.
- NUM_REGS, 32, number of registers; must equal 2**ADDR_WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous and active-low.
- wr_en  input  1  write strobe (RegWrite).
- wr_addr  input  ADDR_WIDTH  destination register index.
- wr_data  input  DATA_WIDTH  write-back data.
- rd_addr_a  input  ADDR_WIDTH  read port A index (rs).
- rd_addr_b  input  ADDR_WIDTH  read port B index (rt).
- rd_data_a  output  DATA_WIDTH  read port A data.
- rd_data_b  output  DATA_WIDTH  read port B data.
- wr_ack  output  1  registered pulse: a write committed on the previous edge.

Behaviour:
- Reset
  - One clock; reset is asynchronous and active-low.
  - rst_n low clears all registers to 0 immediately, without waiting for clk. wr_ack goes to 0.
  - While rst_n is low, rd_data_a and rd_data_b read 0 and writes are ignored.
- Write decode
  - wr_addr is decoded to a one-hot enable vector of NUM_REGS bits, gated by wr_en.
  - Entry 0's enable is permanently masked.
  - On rising clk with rst_n high, wr_en high and wr_addr != 0: reg[wr_addr] <= wr_data.
- Write acknowledge
  - wr_ack <= wr_en & (wr_addr != 0) on each rising edge. It is high for exactly one cycle per committed write.
  - A write to $zero produces no ack and no state change.
- Read (combinational, zero latency)
  - rd_data_x = 0 if rd_addr_x == 0.
  - Otherwise, rd_data_x = wr_data if wr_en and wr_addr == rd_addr_x (same-cycle write-through bypass).
  - Otherwise, rd_data_x = reg[rd_addr_x].
  - Bypass priority is: zero, then bypass, then array. Both ports apply it independently, so both may bypass in the same cycle.
- Timing
  - Write-to-read latency is 0 cycles through the bypass path and 1 cycle through the array.
- Boundary conditions
  - Back-to-back writes to the same index: the last write wins. Each write pulses wr_ack on the cycle after its edge.
  - rst_n asserted in the same cycle as a write: the reset wins and the register stays 0.
  - rst_n deasserted asynchronously mid-cycle: the first write commits on the next rising edge.
  - Index 31 ($ra) behaves like any other entry; there is no wrap-around.
  - X on wr_addr while wr_en is low must not corrupt any entry.
- Widths
  - No arithmetic. All data paths are exactly DATA_WIDTH bits with no truncation.

Test Plan:
- Reset: pulse rst_n low between clock edges -> rd_data_a and rd_data_b read 0 for indices 0-31 immediately, and wr_ack = 0.
- Basic write then read: write 0xDEADBEEF to r8, then next cycle read r8 on A and r9 on B -> A = 0xDEADBEEF, B = 0, and wr_ack is high for 1 cycle.
- $zero protection: wr_en=1, wr_addr=0, wr_data=0xFFFFFFFF -> read r0 = 0 on both ports, and wr_ack stays 0.
- Bypass: in the same cycle, write r31 = 0x12345678 with rd_addr_a = rd_addr_b = 31 -> both outputs show 0x12345678 before the edge; after the edge, the array holds the value.
- Sweep: write r1..r31 = index*0x01010101, then read all pairs (i, 32-i) -> every value matches, and there are exactly 31 wr_ack pulses.
- Reset mid-operation: write r5 = 0xA5A5A5A5, then assert rst_n low in the same cycle as a write r6 = 0x5A5A5A5A -> after release, r5 = 0 and r6 = 0.
